// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU sequencer: state encoding and widths.
package alu_seq_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 4;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_READY  = 3'd2,
    S_EXEC   = 3'd3,
    S_SHOW   = 3'd4
  } state_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// Operator/ALU-facing bus of the sequencer; master is the sequencer, slave the surroundings.
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
);
  import alu_seq_pkg::*;

  logic                go;
  logic [DATA_W-1:0]   data_in;
  logic [OP_W-1:0]     op_sel;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_done;
  logic                alu_start;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   y_reg;
  logic                y_valid;
  logic                err;
  logic [STATE_W-1:0]  state_o;

  modport master (
    input  go, data_in, op_sel, alu_result, alu_done,
    output alu_start, alu_op, a_reg, b_reg, y_reg, y_valid, err, state_o
  );

  modport slave (
    output go, data_in, op_sel, alu_result, alu_done,
    input  alu_start, alu_op, a_reg, b_reg, y_reg, y_valid, err, state_o
  );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge detector producing a one-cycle pulse.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  // [SYNC_STAGES-1:0] is the synchronizer, the top bit holds the previous synced value
  logic [SYNC_STAGES:0] sync_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
      pulse     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-1:0], d};
      pulse     <= sync_pipe[SYNC_STAGES-1] & ~sync_pipe[SYNC_STAGES];
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// Button-driven sequencer: load A, load B, launch ALU with start/done + timeout, show Y.
// Optional accumulator chaining when ALU_SEQ_ACCUM_EN is defined.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int TIMEOUT     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.master  bus
);
  state_e            state, nxt;
  logic              press;
  logic              tmo;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] a_q, b_q, y_q;
  logic [OP_W-1:0]   op_q;
  logic              yv_q, err_q;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_go (
    .clk   (clk),
    .reset (reset),
    .d     (bus.go),
    .pulse (press)
  );

  assign tmo = (cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD_A;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_LOAD_A: if (press) nxt = S_LOAD_B;
      S_LOAD_B: if (press) nxt = S_READY;
      S_READY:  if (press) nxt = S_EXEC;
      // done has priority over the timeout in the same cycle
      S_EXEC:   if (bus.alu_done || tmo) nxt = S_SHOW;
      S_SHOW: begin
`ifdef ALU_SEQ_ACCUM_EN
        if (press) nxt = err_q ? S_LOAD_A : S_LOAD_B;
`else
        if (press) nxt = S_LOAD_A;
`endif
      end
      default:  nxt = S_LOAD_A;
    endcase
  end

  // cnt is cleared at launch and only advances in EXEC, so cnt==0 marks the first EXEC cycle
  always_comb begin
    bus.alu_start = (state == S_EXEC) && (cnt == 8'd0);
    bus.state_o   = state;
    bus.alu_op    = op_q;
    bus.a_reg     = a_q;
    bus.b_reg     = b_q;
    bus.y_reg     = y_q;
    bus.y_valid   = yv_q;
    bus.err       = err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      yv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A: if (press) begin
          a_q   <= bus.data_in;
          yv_q  <= 1'b0;
          err_q <= 1'b0;
        end
        S_LOAD_B: if (press) b_q <= bus.data_in;
        S_READY: if (press) begin
          op_q <= bus.op_sel;
          cnt  <= '0;
        end
        S_EXEC: begin
          if (bus.alu_done) begin
            y_q  <= bus.alu_result;
            yv_q <= 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
            a_q  <= bus.alu_result;
`endif
          end else if (tmo) begin
            y_q   <= '0;
            yv_q  <= 1'b0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random button/ALU traffic
// checked every cycle against a spec-level model.
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  localparam int DW = 8, OW = 4, TMO = 15, SS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(DW), .OP_W(OW)) bus();
  alu_sequencer #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit rnd_sw = 0, spur_en = 0, force_done = 0;
  int fix_delay = -1, fix_res = -1;

  // model state: ms uses the display encoding, mk = cycles already spent in EXEC
  int ms = 0, mk = 0;
  logic [DW-1:0] ma = '0, mb = '0, my = '0;
  logic [OW-1:0] mop = '0;
  logic myv = 1'b0, merr = 1'b0;
  logic [SS+1:0] h = '0;

  // ALU stand-in: answers each launch after a chosen delay (255 = never)
  int pend = 0, rk = 0, rd = 0;
  always @(negedge clk) begin
    #1;
    if (reset && bus.alu_start) begin
      pend = 1; rk = 0;
      rd = (fix_delay >= 0) ? fix_delay
         : (($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 20)));
    end
    if (pend != 0) begin
      bus.alu_done = force_done | (rk == rd);
      if (rk == rd || rk > 40) pend = 0;
      rk++;
    end else begin
      bus.alu_done = force_done | (spur_en && ($urandom_range(0, 5) == 0));
    end
    bus.alu_result = (fix_res >= 0) ? 8'(fix_res) : 8'($urandom);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic press;
    if (!reset) begin
      ms = 0; mk = 0; ma = '0; mb = '0; my = '0; mop = '0; myv = 1'b0; merr = 1'b0; h = '0;
    end else begin
      press = h[SS] & ~h[SS+1];
      h = {h[SS:0], bus.go};
      case (ms)
        0: if (press) begin ma = bus.data_in; myv = 1'b0; merr = 1'b0; ms = 1; end
        1: if (press) begin mb = bus.data_in; ms = 2; end
        2: if (press) begin mop = bus.op_sel; mk = 0; ms = 3; end
        3: begin
          if (bus.alu_done === 1'b1) begin
            my = bus.alu_result; myv = 1'b1; ms = 4;
`ifdef ALU_SEQ_ACCUM_EN
            ma = bus.alu_result;
`endif
          end else if (mk == TMO) begin
            my = '0; myv = 1'b0; merr = 1'b1; ms = 4;
          end else mk++;
        end
        default: if (press) begin
`ifdef ALU_SEQ_ACCUM_EN
          ms = merr ? 0 : 1;
`else
          ms = 0;
`endif
        end
      endcase
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({bus.alu_start, bus.alu_op, bus.a_reg, bus.b_reg, bus.y_reg,
                bus.y_valid, bus.err, bus.state_o});
  endfunction

  task automatic tick();
    logic st;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    st = (ms == 3) && (mk == 0);
    chk("outputs", dut_vec(), 64'({st, mop, ma, mb, my, myv, merr, 3'(ms)}));
    @(negedge clk);
    if (rnd_sw) begin bus.data_in = 8'($urandom); bus.op_sel = 4'($urandom); end
  endtask

  task automatic press(input logic [7:0] v, input logic [3:0] o, input int hold);
    bus.go = 1'b1;
    if (!rnd_sw) begin bus.data_in = v; bus.op_sel = o; end
    repeat (hold) tick();
    bus.go = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    for (int i = 0; i < budget && bus.state_o != 3'(s); i++) tick();
    chk(nm, 64'(bus.state_o), 64'(s));
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input int delay, input int res);
    press(a, 4'h0, 5);
    press(b, 4'h0, 5);
    fix_delay = delay; fix_res = res;
    press(8'h00, op, 5);
    wait_state(4, 40, "op_show");
    fix_delay = -1; fix_res = -1;
  endtask

  initial begin
    reset = 1'b0; bus.go = 1'b0; bus.data_in = '0; bus.op_sel = '0;
    repeat (3) tick();
    reset = 1'b1;

    // idle after reset
    repeat (100) tick();
    chk("idle_all", dut_vec(), 64'd0);

    // held button loads A exactly once, switch wiggle does not touch B
    bus.data_in = 8'h2A; bus.go = 1'b1;
    repeat (50) tick();
    bus.go = 1'b0;
    repeat (3) tick();
    chk("hold_state", 64'(bus.state_o), 64'd1);
    chk("hold_a", 64'(bus.a_reg), 64'h2A);
    for (int i = 0; i < 20; i++) begin bus.data_in = 8'($urandom); tick(); end
    chk("wiggle_b", 64'(bus.b_reg), 64'd0);
    chk("wiggle_state", 64'(bus.state_o), 64'd1);
    press(8'h05, 4'h0, 5);
    chk("load_b", 64'(bus.b_reg), 64'h05);
    chk("ready_state", 64'(bus.state_o), 64'd2);
    fix_delay = 3; fix_res = 8'h2F;
    press(8'h00, 4'h1, 5);
    wait_state(4, 40, "basic_show");
    fix_delay = -1; fix_res = -1;
    chk("basic_y", 64'(bus.y_reg), 64'h2F);
    chk("basic_yv", 64'(bus.y_valid), 64'd1);
    chk("basic_op", 64'(bus.alu_op), 64'h1);
    chk("basic_err", 64'(bus.err), 64'd0);
    chk("model_y", 64'(my), 64'h2F);
`ifndef ALU_SEQ_ACCUM_EN
    chk("basic_a", 64'(bus.a_reg), 64'h2A);
`endif

    // no answer: timeout
    do_reset();
    do_op(8'h11, 8'h22, 4'h3, 255, -1);
    chk("tmo_err", 64'(bus.err), 64'd1);
    chk("tmo_y", 64'(bus.y_reg), 64'd0);
    chk("tmo_yv", 64'(bus.y_valid), 64'd0);
    chk("model_err", 64'(merr), 64'd1);

    // answer on the last allowed cycle wins over the timeout
    do_reset();
    do_op(8'h33, 8'h44, 4'h5, TMO, 8'h5A);
    chk("edge_err", 64'(bus.err), 64'd0);
    chk("edge_y", 64'(bus.y_reg), 64'h5A);
    chk("edge_yv", 64'(bus.y_valid), 64'd1);

    // reset mid-EXEC, late done afterwards is ignored
    do_reset();
    press(8'h66, 4'h0, 5);
    press(8'h77, 4'h0, 5);
    fix_delay = 255;
    bus.op_sel = 4'h7; bus.go = 1'b1;
    for (int i = 0; i < 20 && !bus.alu_start; i++) tick();
    chk("start_seen", 64'(bus.alu_start), 64'd1);
    bus.go = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    fix_res = 8'hFF; force_done = 1'b1;
    tick();
    force_done = 1'b0; fix_delay = -1; fix_res = -1;
    repeat (3) tick();
    chk("rst_exec_all", dut_vec(), 64'd0);

`ifdef ALU_SEQ_ACCUM_EN
    do_reset();
    do_op(8'h10, 8'h03, 4'h0, 2, 8'h13);
    chk("acc_y1", 64'(bus.y_reg), 64'h13);
    press(8'h00, 4'h0, 5);
    chk("acc_state", 64'(bus.state_o), 64'd1);
    chk("acc_a", 64'(bus.a_reg), 64'h13);
    press(8'h01, 4'h0, 5);
    fix_delay = 1; fix_res = 8'h14;
    press(8'h00, 4'h0, 5);
    wait_state(4, 40, "acc_show");
    fix_delay = -1; fix_res = -1;
    chk("acc_y2", 64'(bus.y_reg), 64'h14);
    chk("acc_b", 64'(bus.b_reg), 64'h01);
`endif

    // random traffic
    do_reset();
    rnd_sw = 1; spur_en = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      press(8'h00, 4'h0, int'($urandom_range(1, 6)));
      repeat ($urandom_range(0, 8)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that sequences the 8-bit ALU datapath from one operator button.
- Successive presses load operand A from the switches, load operand B, then launch the selected operation; the block latches the result Y.
- Sits between the debounced button/switch inputs and the ALU operation mux in the top level.
- Drives the A/B/Y registers shown on the LEDs and display, and supervises the ALU with a start/done handshake plus a timeout.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 4, operation selector width.
- TIMEOUT, 15, max cycles in EXEC waiting for alu_done before flagging an error (1..255).
- SYNC_STAGES, 2, flip-flops in the go-input synchronizer (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; clears all state
- go  input  1  debounced operator button, level, asynchronous to clk
- data_in  input  DATA_W  switch operand value
- op_sel  input  OP_W  switch operation selector
- alu_result  input  DATA_W  ALU result, valid when alu_done=1
- alu_done  input  1  ALU completion strobe
- alu_start  output  1  one-cycle launch pulse to ALU
- alu_op  output  OP_W  operation latched at launch, held stable through EXEC
- a_reg  output  DATA_W  operand A register (also to led[15:8])
- b_reg  output  DATA_W  operand B register (also to led[7:0])
- y_reg  output  DATA_W  latched result
- y_valid  output  1  y_reg holds a completed result
- err  output  1  last operation timed out
- state_o  output  3  current state encoding, for display/debug

Behaviour:
- Reset (reset=0, async): state=LOAD_A; a_reg, b_reg, y_reg, alu_op, timeout counter = 0; alu_start=0, y_valid=0, err=0.
- go passes through SYNC_STAGES flops, then a rising-edge detector. press = one-cycle pulse asserted SYNC_STAGES+1 cycles after go rises. Held go gives exactly one press; press requires go to return low first.
- States and transitions:
  - LOAD_A: on press, a_reg<=data_in; y_valid<=0; err<=0 -> LOAD_B.
  - LOAD_B: on press, b_reg<=data_in -> READY.
  - READY: on press, alu_op<=op_sel, alu_start=1 for exactly that next cycle, counter<=0 -> EXEC.
  - EXEC: press ignored. On alu_done: y_reg<=alu_result, y_valid<=1 -> SHOW. Otherwise counter++; when counter reaches TIMEOUT with no done: y_reg<=0, err<=1, y_valid<=0 -> SHOW.
  - SHOW: outputs held. On press -> LOAD_A, with a_reg/b_reg/y_reg retained until overwritten.
- alu_done in the same cycle the counter hits TIMEOUT: done wins; no error.
- alu_done outside EXEC is ignored.
- data_in/op_sel are sampled only in the press cycle. Switch changes at other times have no effect.
- alu_op, a_reg, b_reg never change while in EXEC.
- Reset asserted mid-EXEC: immediate return to reset values. A late alu_done after reset release is ignored (state is LOAD_A).
- state_o: LOAD_A=0, LOAD_B=1, READY=2, EXEC=3, SHOW=4.

Optional Feature:
- Macro ALU_SEQ_ACCUM_EN.
- Defined: on successful completion, a_reg<=alu_result in the same cycle y_reg is written. SHOW press goes to LOAD_B instead of LOAD_A (accumulator chaining). A timeout still returns to LOAD_A.
- Undefined: behaviour exactly as above; a_reg is written only in LOAD_A.

Decomposition:
- Package alu_seq_pkg: state enumeration with the encodings above, default DATA_W/OP_W constants, state_o width.
- One sub-module, sync_edge_det: SYNC_STAGES synchronizer plus rising-edge pulse generator, with its own clk/reset.

Test Plan:
- Reset then no go for 100 cycles -> all outputs 0, state_o=0.
- Presses with data_in=0x2A, then 0x05, then op_sel=0x1; ALU returns 0x2F with alu_done 3 cycles after start -> a_reg=0x2A, b_reg=0x05, alu_start one cycle, alu_op=0x1, y_reg=0x2F, y_valid=1, state_o=4.
- Hold go high 50 cycles in LOAD_A -> exactly one load, state_o=1. Toggle data_in during LOAD_B without press -> b_reg unchanged.
- Launch with alu_done never asserted -> after TIMEOUT=15 cycles err=1, y_reg=0, state_o=4. Repeat with done on cycle 15 -> err=0, result latched.
- Assert reset two cycles into EXEC, then pulse alu_done after release -> all zero, state_o=0, y_valid=0.
- With ALU_SEQ_ACCUM_EN: A=0x10, B=0x03, result 0x13, then SHOW press -> a_reg=0x13, state_o=1. Next B=0x01, result 0x14.
